// File: rtl/bram_rd_fetcher.sv
// BRAM read master: fetches i_word_cnt words from i_base_addr into a small FIFO, streamed on valid/ready.
// Build with BRAM_RD_TIMEOUT_EN to add a done-watchdog that aborts the run and raises sticky o_err.
module bram_rd_fetcher #(
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W-1:0] i_word_cnt,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_bram_addr,
   output logic              o_bram_trig,
   input  logic [DATA_W-1:0] i_bram_data,
   input  logic              i_bram_done,
   output logic [DATA_W-1:0] o_pix_data,
   output logic              o_pix_valid,
   input  logic              i_pix_ready,
   output logic              o_err
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("bram_rd_fetcher: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DRAIN} state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   remain_q;
   logic                trig_q;
   logic                busy_q;
   logic                done_q;

   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic                valid_q;

   logic                fifo_wr;
   logic                fifo_rd;
   logic                has_space;
   logic                wd_fire;

   // A write only happens on done, and trig is only raised with a free slot, so the FIFO never overflows.
   assign fifo_wr   = trig_q & i_bram_done;
   assign fifo_rd   = valid_q & i_pix_ready;
   assign has_space = (cnt_q < DEPTH_C);

`ifdef BRAM_RD_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q;
   logic            err_q;

   assign wd_fire = trig_q & ~i_bram_done & (wd_q == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (!trig_q || i_bram_done || wd_fire) begin
            wd_q <= '0;
         end else begin
            wd_q <= wd_q + 1'b1;
         end
         if (wd_fire) begin
            err_q <= 1'b1;
         end
      end
   end

   assign o_err = err_q;
`else
   assign wd_fire = 1'b0;
   assign o_err   = 1'b0;
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (wd_fire) begin
         cnt_d = '0;
      end else begin
         case ({fifo_wr, fifo_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= (cnt_d != '0);
         if (wd_fire) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (fifo_wr) begin
               mem_q[wr_ptr_q] <= i_bram_data;
               wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (fifo_rd) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end
         end
      end
   end

   // busy stays high through the done cycle and drops in the following IDLE cycle.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         trig_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               busy_q <= 1'b0;
               if (i_start) begin
                  busy_q   <= 1'b1;
                  addr_q   <= i_base_addr;
                  remain_q <= i_word_cnt;
                  if (i_word_cnt == '0) begin
                     state_q <= S_DRAIN;
                  end else begin
                     state_q <= S_REQ;
                     trig_q  <= has_space;
                  end
               end
            end
            S_REQ: begin
               if (wd_fire) begin
                  trig_q  <= 1'b0;
                  state_q <= S_DRAIN;
               end else if (trig_q) begin
                  if (i_bram_done) begin
                     trig_q   <= 1'b0;
                     addr_q   <= addr_q + 1'b1;
                     remain_q <= remain_q - 1'b1;
                     state_q  <= S_GAP;
                  end
               end else if (has_space) begin
                  trig_q <= 1'b1;
               end
            end
            // One trig-low cycle lets the slave restart its latency count.
            S_GAP: begin
               if (remain_q != '0) begin
                  state_q <= S_REQ;
                  trig_q  <= has_space;
               end else begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (cnt_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               trig_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_bram_addr = addr_q;
   assign o_bram_trig = trig_q;
   assign o_pix_data  = mem_q[rd_ptr_q];
   assign o_pix_valid = valid_q;

endmodule

// File: doc/bram_rd_fetcher.md
Name: bram_rd_fetcher

Overview:
- Read master that drives the trig/done BRAM read port used in the connected-domain filter sim and RTL.
- On a start command, fetches a run of consecutive 32-bit words from BRAM, buffers them in a small FIFO, and presents them downstream on a valid/ready stream.
- Issues a read only when buffer space is guaranteed, so downstream backpressure never loses data.

Parameters:
- FIFO_DEPTH, 4, output buffer depth in words; power of two, >=2
- ADDR_W, 13, BRAM address width
- DATA_W, 32, BRAM word width
- TIMEOUT_CYC, 255, cycles to wait for done before abort (used only with optional feature)

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse, sampled only in IDLE
- i_base_addr  in  ADDR_W  first word address, captured with i_start
- i_word_cnt  in  ADDR_W  number of words to fetch, captured with i_start
- o_busy  out  1  high from the cycle after an accepted start until the o_done cycle, inclusive
- o_done  out  1  one-cycle pulse, run complete
- o_bram_addr  out  ADDR_W  read address, stable while o_bram_trig is high
- o_bram_trig  out  1  read request, held until done
- i_bram_data  in  DATA_W  read data, valid when i_bram_done is high
- i_bram_done  in  1  read complete; only meaningful while o_bram_trig is high
- o_pix_data  out  DATA_W  stream data (FIFO head)
- o_pix_valid  out  1  FIFO not empty
- i_pix_ready  in  1  downstream accept; a transfer occurs when valid and ready are both high
- o_err  out  1  sticky timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- All outputs are registered. o_pix_data and o_pix_valid come from FIFO registers.
- FSM states:
  - IDLE: on i_start, latch base and count, assert o_busy. If count==0, go to DRAIN; otherwise go to REQ.
  - REQ: o_bram_trig=1 and o_bram_addr=current address. The request is issued only if (FIFO count + 1) <= FIFO_DEPTH; otherwise trig stays low and the FSM waits in REQ. On a cycle where trig=1 and i_bram_done=1:
    - write i_bram_data into the FIFO;
    - address <= address+1, wrapping modulo 2^ADDR_W (8191 -> 0);
    - remaining <= remaining-1;
    - go to GAP.
  - GAP: trig=0 for exactly one cycle, which resets the slave's latency counter. Go to REQ if remaining>0, else DRAIN.
  - DRAIN: wait for the FIFO to empty, then pulse o_done for one cycle, deassert o_busy, and return to IDLE.
- i_bram_done while trig is low is ignored.
- i_start outside IDLE is ignored; busy and the current run are unaffected.
- FIFO boundary rules:
  - Simultaneous write and read when full is impossible by construction.
  - Simultaneous write and read at any count leaves the count unchanged.
  - A read when empty is a no-op.
- Data ordering: strictly increasing address order, including across wrap.
- Asynchronous reset mid-run: trig drops immediately, the FIFO is flushed, and any partially fetched words are discarded.
- Throughput: one word per 2+L cycles, where L is the slave latency.

Optional Feature:
- Macro: BRAM_RD_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in REQ with trig high and done low.
  - When it reaches TIMEOUT_CYC, set o_err (sticky until reset), drop trig, flush the FIFO, and go to DRAIN. o_done then pulses on the next cycle.
  - The counter clears on each done.
- Undefined: no watchdog logic; o_err is constant 0; REQ waits indefinitely.

Test Plan:
- Basic run against a slave with read latency 1 that returns {19'h0, addr}. Start base=10, cnt=5, ready=1 -> stream 10,11,12,13,14 in order; trig low exactly one cycle between reads; single o_done pulse after the last transfer; busy low afterwards.
- Backpressure: base=0, cnt=8, ready=0 for 40 cycles, then 1 -> at most 4 reads issued before stall; trig stays low while the FIFO is full; all 8 words delivered in order; no loss or duplication.
- Wrap: base=8190, cnt=4 -> data 8190, 8191, 0, 1.
- Zero count and ignored start: cnt=0 -> o_done two cycles after start with no trig ever. A second i_start during a cnt=6 run -> ignored; exactly 6 words delivered.
- Reset mid-run: assert i_rstn=0 after the 3rd of 6 words -> trig, valid, busy, and done all 0 at once. A new run with base=100, cnt=2 -> 100, 101 only.
- Timeout (BRAM_RD_TIMEOUT_EN, TIMEOUT_CYC=20): slave never asserts done -> o_err=1 and trig low after 20 trig-high cycles; one o_done pulse follows; o_err holds until reset.
